// File: rtl/inv_butterfly_ser.sv
// Serial inverse radix-2 butterfly: y1,y2 in -> a=(y1+y2)>>>1, b=(y1-y2)>>>1 out, per component.
// a valid the cycle after y2 is taken, b after a is taken; input stalls while results are pending, outputs hold under backpressure.
module inv_butterfly_ser #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         inexact
);
    localparam int H = n / 2;

    typedef enum logic [1:0] {S_Y1, S_Y2, S_OUT_A, S_OUT_B} state_t;

    state_t       state_q, state_d;
    logic [n-1:0] y1_q, y1_d;
    logic [n-1:0] a_q, a_d;
    logic [n-1:0] b_q, b_d;
    logic         inexact_q, inexact_d;

    logic signed [H:0] y1_re, y1_im, y2_re, y2_im;
    logic signed [H:0] a_re, a_im, b_re, b_im;
    logic              in_fire, out_fire;

    // One guard bit is enough: sums and differences of two H-bit values fit in H+1 bits.
    assign y1_re = {y1_q[n-1], y1_q[n-1:H]};
    assign y1_im = {y1_q[H-1], y1_q[H-1:0]};
    assign y2_re = {in_data[n-1], in_data[n-1:H]};
    assign y2_im = {in_data[H-1], in_data[H-1:0]};

    assign a_re = y1_re + y2_re;
    assign a_im = y1_im + y2_im;
    assign b_re = y1_re - y2_re;
    assign b_im = y1_im - y2_im;

    assign in_ready  = (state_q == S_Y1) || (state_q == S_Y2);
    assign out_valid = (state_q == S_OUT_A) || (state_q == S_OUT_B);
    assign out_last  = (state_q == S_OUT_B);
    assign out_data  = out_last ? b_q : a_q;
    assign inexact   = inexact_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        y1_d      = y1_q;
        a_d       = a_q;
        b_d       = b_q;
        inexact_d = inexact_q;
        case (state_q)
            S_Y1: begin
                if (in_fire) begin
                    y1_d    = in_data;
                    state_d = S_Y2;
                end
            end
            S_Y2: begin
                if (in_fire) begin
                    // Dropping bit 0 of each result is the floor halving.
                    a_d       = {a_re[H:1], a_im[H:1]};
                    b_d       = {b_re[H:1], b_im[H:1]};
                    inexact_d = inexact_q | a_re[0] | a_im[0] | b_re[0] | b_im[0];
                    state_d   = S_OUT_A;
                end
            end
            S_OUT_A: begin
                if (out_fire) state_d = S_OUT_B;
            end
            S_OUT_B: begin
                if (out_fire) state_d = S_Y1;
            end
            default: state_d = S_Y1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_Y1;
            y1_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            y1_q      <= y1_d;
            a_q       <= a_d;
            b_q       <= b_d;
            inexact_q <= inexact_d;
        end
    end
endmodule

// File: tb/tb_inv_butterfly_ser.sv
// Bench for inv_butterfly_ser: integer reference model, scoreboard queue and directed/random stimulus.
module tb_inv_butterfly_ser;
    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        inexact;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [16:0] exp_q[$];
    bit          m_inexact = 0;
    bit          rnd_out = 0;
    bit          hold_ready = 1;

    inv_butterfly_ser #(.n(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .inexact(inexact)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready changes 2 time units after the edge, after the main thread's updates.
    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rnd_out ? ($urandom_range(0, 1) == 1) : hold_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Floor division by two on plain integers.
    function automatic int fdiv2(input int s);
        if (s >= 0) return s / 2;
        return -((-s + 1) / 2);
    endfunction

    task automatic model_pair(input logic [15:0] y1, input logic [15:0] y2,
                              output logic [15:0] a, output logic [15:0] b, output bit inx);
        int r1, i1, r2, i2, sar, sai, sbr, sbi;
        r1 = int'($signed(y1[15:8]));
        i1 = int'($signed(y1[7:0]));
        r2 = int'($signed(y2[15:8]));
        i2 = int'($signed(y2[7:0]));
        sar = r1 + r2;
        sai = i1 + i2;
        sbr = r1 - r2;
        sbi = i1 - i2;
        a = {8'(fdiv2(sar)), 8'(fdiv2(sai))};
        b = {8'(fdiv2(sbr)), 8'(fdiv2(sbi))};
        inx = (sar % 2 != 0) || (sai % 2 != 0) || (sbr % 2 != 0) || (sbi % 2 != 0);
    endtask

    task automatic pin(input string nm, input logic [15:0] y1, input logic [15:0] y2,
                       input logic [15:0] ea, input logic [15:0] eb, input bit einx);
        logic [15:0] a, b;
        bit inx;
        model_pair(y1, y2, a, b, inx);
        check({nm, "_model_a"}, a, ea);
        check({nm, "_model_b"}, b, eb);
        check({nm, "_model_inexact"}, inx, einx);
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic send_word(input logic [15:0] w, input bit rnd);
        int g;
        bit acc;
        g = 0;
        forever begin
            if (!in_ready) begin
                in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
                in_data  = 16'($urandom);
            end else if (rnd && $urandom_range(0, 2) == 0) begin
                in_valid = 0;
                in_data  = 16'($urandom);
            end else begin
                in_valid = 1;
                in_data  = w;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            g++;
            if (g > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stalled required=accepted");
                break;
            end
        end
        in_valid = 0;
    endtask

    task automatic send_pair(input logic [15:0] y1, input logic [15:0] y2, input bit rnd);
        logic [15:0] a, b;
        bit inx;
        send_word(y1, rnd);
        send_word(y2, rnd);
        model_pair(y1, y2, a, b, inx);
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b1, b});
        m_inexact = m_inexact | inx;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_done", (g < 500), 1);
    endtask

    logic [15:0] prev_data;
    logic        prev_last;
    bit          prev_stall = 0;
    logic [16:0] mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            check("in_ready_vs_out_valid", in_ready, !out_valid);
            check("inexact_flag", inexact, m_inexact);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=no_output", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", out_data, mon_e[15:0]);
                    check("out_last", out_last, mon_e[16]);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        int c0;
        logic [7:0] i8, j8, k8;
        rst_n    = 1;
        in_valid = 0;
        in_data  = 0;
        #3 rst_n = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_inexact", inexact, 0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        pin("v029", 16'h0A04, 16'h0602, 16'h0803, 16'h0201, 0);
        pin("v030", 16'h0000, 16'h0300, 16'h0100, 16'hFE00, 1);
        pin("v031a", 16'h7F80, 16'h7F80, 16'h7F80, 16'h0000, 0);
        pin("v031b", 16'h807F, 16'h7F80, 16'hFFFF, 16'h807F, 1);
        pin("vbp", 16'h2010, 16'h0C08, 16'h160C, 16'h0A04, 0);

        send_pair(16'h0A04, 16'h0602, 0);
        check("v029_dut_a", out_data, 16'h0803);
        check("v029_dut_last", out_last, 0);
        drain();
        check("v029_dut_inexact", inexact, 0);
        send_pair(16'h0000, 16'h0300, 0);
        drain();
        check("v030_dut_inexact", inexact, 1);
        send_pair(16'h7F80, 16'h7F80, 0);
        send_pair(16'h807F, 16'h7F80, 0);
        drain();

        // Stalled output: junk input pulses must be ignored.
        hold_ready = 0;
        send_pair(16'h2010, 16'h0C08, 0);
        repeat (5) begin
            in_valid = 1;
            in_data  = 16'($urandom);
            @(posedge clk);
            #1;
            check("bp_data", out_data, 16'h160C);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid   = 0;
        hold_ready = 1;
        drain();

        // Reset with y1 already captured.
        send_word(16'h1111, 0);
        rst_n = 0;
        exp_q.delete();
        m_inexact = 0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_inexact", inexact, 0);
        @(posedge clk);
        #1 rst_n = 1;
        send_pair(16'h0202, 16'h0202, 0);
        check("midrst_dut_a", out_data, 16'h0202);
        drain();

        // Full-rate burst of 8 pairs.
        c0 = cyc;
        for (int p = 0; p < 8; p++) send_pair(16'($urandom), 16'($urandom), 0);
        begin
            int g;
            g = 0;
            while (out_valid && g < 50) begin
                @(posedge clk);
                #1;
                g++;
            end
        end
        check("throughput_cycles", cyc - c0, 32);
        drain();

        // Every component value appears on both operands.
        for (int i = 0; i < 256; i++) begin
            i8 = 8'(i);
            j8 = 8'(i * 37 + 11);
            k8 = 8'(255 - i * 3);
            send_pair({i8, ~i8}, {j8, k8}, 0);
        end
        drain();

        rnd_out = 1;
        for (int p = 0; p < 100; p++) send_pair(16'($urandom), 16'($urandom), 1);
        rnd_out    = 0;
        hold_ready = 1;
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
